// File: rtl/wb_button_led_master.sv
// wb_button_led_master
//   Single Wishbone classic initiator for the buttons/LEDs example. Every
//   POLL_PERIOD cycles it reads the button/switch register. When the value
//   differs from the last one written out (or nothing has been written yet),
//   it writes the green LED register and then the RGB LED register.
//
// Ports
//   clk_i, rst_i          clock, asynchronous active-high reset
//   wb_cyc_o, wb_stb_o    bus cycle / strobe (registered, held until termination)
//   wb_we_o, wb_adr_o     direction and byte address of the current transfer
//   wb_dat_o, wb_sel_o    write data, byte selects (4'hF during a cycle)
//   wb_dat_i              read data: [3:0] buttons, [7:4] switches
//   wb_ack_i, wb_err_i    slave termination
//   busy_o                sequencer not idle
//   bus_err_o             sticky: a transfer ended with err or timed out
//   last_in_o             last {switches,buttons} that was fully written out
module wb_button_led_master #(
  parameter int unsigned POLL_PERIOD = 5_000_000,
  parameter int unsigned TIMEOUT     = 255,
  parameter logic [31:0] BTN_ADDR    = 32'h0000_0000,
  parameter logic [31:0] GREEN_ADDR  = 32'h0000_0010,
  parameter logic [31:0] RGB_ADDR    = 32'h0000_0014
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  output logic        busy_o,
  output logic        bus_err_o,
  output logic [7:0]  last_in_o
);

  localparam int unsigned PW = $clog2(POLL_PERIOD);
  localparam int unsigned WW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  // Gap states give the mandatory one idle bus cycle between transfers.
  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_BTN,
    S_GAP_G,
    S_WR_GREEN,
    S_GAP_R,
    S_WR_RGB
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] poll_q, poll_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [7:0]    in_q, in_d;
  logic [7:0]    last_q, last_d;
  logic          valid_q, valid_d;
  logic          berr_q, berr_d;

  logic          cyc_q, cyc_d;
  logic          we_q, we_d;
  logic [31:0]   adr_q, adr_d;
  logic [31:0]   dat_q, dat_d;

  logic          tick;
  logic          ack_ok;
  logic          err_hit;
  logic          timed_out;
  logic          abort;
  logic          in_xfer;

  // Only the low byte of the button register carries information.
  logic          unused_dat;
  assign unused_dat = ^wb_dat_i[31:8];

  function automatic logic [11:0] rgb_of(input logic [7:0] v);
    logic [11:0] r;
    r = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      r[3*i +: 3] = {v[i], v[4+i], v[i] & v[4+i]};
    end
    return r;
  endfunction

  // Free-running poll counter; ticks outside IDLE are simply not acted upon.
  assign tick   = (poll_q == PW'(POLL_PERIOD - 1));
  assign poll_d = tick ? '0 : poll_q + PW'(1);

  assign in_xfer   = (state_q == S_RD_BTN) || (state_q == S_WR_GREEN) ||
                     (state_q == S_WR_RGB);
  // err wins over a simultaneous ack; both are ignored while stb is low.
  assign err_hit   = cyc_q && wb_err_i;
  assign ack_ok    = cyc_q && wb_ack_i && !wb_err_i;
  assign timed_out = cyc_q && !wb_ack_i && !wb_err_i &&
                     (wait_q == WW'(TIMEOUT - 1));
  assign abort     = in_xfer && (err_hit || timed_out);

  always_comb begin
    state_d = state_q;
    in_d    = in_q;
    last_d  = last_q;
    valid_d = valid_q;
    berr_d  = berr_q;

    case (state_q)
      S_IDLE:     if (tick) state_d = S_RD_BTN;
      S_RD_BTN: begin
        if (ack_ok) begin
          in_d = wb_dat_i[7:0];
          if (valid_q && (wb_dat_i[7:0] == last_q)) state_d = S_IDLE;
          else                                      state_d = S_GAP_G;
        end
      end
      S_GAP_G:    state_d = S_WR_GREEN;
      S_WR_GREEN: if (ack_ok) state_d = S_GAP_R;
      S_GAP_R:    state_d = S_WR_RGB;
      S_WR_RGB: begin
        if (ack_ok) begin
          last_d  = in_q;
          valid_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      default:    state_d = S_IDLE;
    endcase

    if (abort) begin
      state_d = S_IDLE;
      berr_d  = 1'b1;
    end

    // Counts stb cycles of the current transfer; zero at every transfer start.
    wait_d = (cyc_q && (state_d == state_q)) ? wait_q + WW'(1) : '0;

    // Bus outputs are registered from the next state so they are glitch-free
    // and already valid in the first cycle of each transfer.
    cyc_d = 1'b0;
    we_d  = 1'b0;
    adr_d = '0;
    dat_d = '0;
    case (state_d)
      S_RD_BTN: begin
        cyc_d = 1'b1;
        adr_d = BTN_ADDR;
      end
      S_WR_GREEN: begin
        cyc_d = 1'b1;
        we_d  = 1'b1;
        adr_d = GREEN_ADDR;
        dat_d = {28'b0, in_d[3:0]};
      end
      S_WR_RGB: begin
        cyc_d = 1'b1;
        we_d  = 1'b1;
        adr_d = RGB_ADDR;
        dat_d = {20'b0, rgb_of(in_d)};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      poll_q  <= '0;
      wait_q  <= '0;
      in_q    <= '0;
      last_q  <= '0;
      valid_q <= 1'b0;
      berr_q  <= 1'b0;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      poll_q  <= poll_d;
      wait_q  <= wait_d;
      in_q    <= in_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      berr_q  <= berr_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
    end
  end

  assign wb_cyc_o  = cyc_q;
  assign wb_stb_o  = cyc_q;
  assign wb_we_o   = we_q;
  assign wb_adr_o  = adr_q;
  assign wb_dat_o  = dat_q;
  assign wb_sel_o  = cyc_q ? 4'hF : 4'h0;
  assign busy_o    = (state_q != S_IDLE);
  assign bus_err_o = berr_q;
  assign last_in_o = last_q;

endmodule
